// File: rtl/adc_frame_align.sv
// Frame-clock word aligner: steps bitslip and IODELAY taps until the deserialized
// frame word matches PATTERN, then monitors it for errors while locked.
module adc_frame_align #(
  parameter logic [5:0]  PATTERN = 6'b111000,
  parameter int unsigned SETTLE  = 8,
  parameter int unsigned CHECK   = 16,
  parameter int unsigned MAXTAP  = 31
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        START,
  input  logic [5:0]  FRAME,
  output logic        BS,
  output logic        DINC,
  output logic        DRST,
  output logic        LOCKED,
  output logic        FAIL,
  output logic [4:0]  TAP,
  output logic [2:0]  SLIP,
  output logic [15:0] ERRCNT
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] CHECK_LAST  = 8'(CHECK - 1);
  localparam logic [4:0] TAP_LAST    = 5'(MAXTAP);
  localparam logic [2:0] SLIP_LAST   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRESET,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIPS,
    ST_INC,
    ST_LOCK,
    ST_FAILED
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  settle_cnt_q, settle_cnt_d;
  logic [7:0]  match_cnt_q, match_cnt_d;
  logic [4:0]  tap_q, tap_d;
  logic [2:0]  slip_q, slip_d;
  logic [15:0] errcnt_q, errcnt_d;
  logic        bs_q, bs_d;
  logic        dinc_q, dinc_d;
  logic        drst_q, drst_d;
  logic        locked_q, locked_d;
  logic        fail_q, fail_d;
  logic        frame_ok;

  assign frame_ok = (FRAME == PATTERN);

  // Outputs are computed alongside the next state so every port comes from a flop.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    match_cnt_d  = match_cnt_q;
    tap_d        = tap_q;
    slip_d       = slip_q;
    errcnt_d     = errcnt_q;
    bs_d         = 1'b0;
    dinc_d       = 1'b0;
    drst_d       = 1'b0;
    locked_d     = locked_q;
    fail_d       = fail_q;

    if (START) begin
      state_d      = ST_DRESET;
      drst_d       = 1'b1;
      settle_cnt_d = 8'd0;
      match_cnt_d  = 8'd0;
      tap_d        = 5'd0;
      slip_d       = 3'd0;
      errcnt_d     = 16'd0;
      locked_d     = 1'b0;
      fail_d       = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_DRESET, ST_SLIPS, ST_INC: begin
          state_d      = ST_SETTLE;
          settle_cnt_d = SETTLE_LAST;
        end
        ST_SETTLE: begin
          if (settle_cnt_q == 8'd0) begin
            state_d     = ST_CHECK;
            match_cnt_d = 8'd0;
          end else begin
            settle_cnt_d = settle_cnt_q - 8'd1;
          end
        end
        ST_CHECK: begin
          if (frame_ok) begin
            if (match_cnt_q == CHECK_LAST) begin
              state_d  = ST_LOCK;
              locked_d = 1'b1;
            end else begin
              match_cnt_d = match_cnt_q + 8'd1;
            end
          end else if (slip_q < SLIP_LAST) begin
            state_d = ST_SLIPS;
            bs_d    = 1'b1;
            slip_d  = slip_q + 3'd1;
          end else if (tap_q < TAP_LAST) begin
            state_d = ST_INC;
            dinc_d  = 1'b1;
            tap_d   = tap_q + 5'd1;
            slip_d  = 3'd0;
          end else begin
            state_d = ST_FAILED;
            fail_d  = 1'b1;
            tap_d   = TAP_LAST;
            slip_d  = SLIP_LAST;
          end
        end
        ST_LOCK: begin
          if (!frame_ok && (errcnt_q != 16'hFFFF)) begin
            errcnt_d = errcnt_q + 16'd1;
          end
        end
        ST_FAILED: begin
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= 8'd0;
      match_cnt_q  <= 8'd0;
      tap_q        <= 5'd0;
      slip_q       <= 3'd0;
      errcnt_q     <= 16'd0;
      bs_q         <= 1'b0;
      dinc_q       <= 1'b0;
      drst_q       <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      match_cnt_q  <= match_cnt_d;
      tap_q        <= tap_d;
      slip_q       <= slip_d;
      errcnt_q     <= errcnt_d;
      bs_q         <= bs_d;
      dinc_q       <= dinc_d;
      drst_q       <= drst_d;
      locked_q     <= locked_d;
      fail_q       <= fail_d;
    end
  end

  assign BS     = bs_q;
  assign DINC   = dinc_q;
  assign DRST   = drst_q;
  assign LOCKED = locked_q;
  assign FAIL   = fail_q;
  assign TAP    = tap_q;
  assign SLIP   = slip_q;
  assign ERRCNT = errcnt_q;

endmodule

// File: tb/tb_adc_frame_align.sv
// Scoreboard bench for adc_frame_align: stimulus queues expected pulse events and
// status snapshots, a negedge monitor pops and compares them against both instances.
module tb_adc_frame_align;

  localparam logic [5:0] PAT = 6'b111000;

  localparam logic [4:0] K_DRST = 5'b00001;
  localparam logic [4:0] K_BS   = 5'b00010;
  localparam logic [4:0] K_DINC = 5'b00100;
  localparam logic [4:0] K_LOCK = 5'b01000;
  localparam logic [4:0] K_FAIL = 5'b10000;

  typedef struct {
    int          stamp;
    logic [4:0]  kind;
    logic [4:0]  tap;
    logic [2:0]  slip;
    logic [15:0] err;
  } ev_t;

  typedef struct {
    int          stamp;
    bit          inst;
    string       name;
    logic        locked;
    logic        fail;
    logic [4:0]  tap;
    logic [2:0]  slip;
    logic [15:0] err;
  } snap_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rstn;
  logic        start_m;
  logic        start_f;
  logic        use_model;
  logic [5:0]  frame_drv;
  logic [5:0]  frame_m;

  logic        bs_m, dinc_m, drst_m, locked_m, fail_m;
  logic [4:0]  tap_m;
  logic [2:0]  slip_m;
  logic [15:0] err_m;
  logic        bs_f, dinc_f, drst_f, locked_f, fail_f;
  logic [4:0]  tap_f;
  logic [2:0]  slip_f;
  logic [15:0] err_f;

  adc_frame_align #(.PATTERN(PAT)) u_main (
    .CLK(clk), .RSTn(rstn), .START(start_m), .FRAME(frame_m),
    .BS(bs_m), .DINC(dinc_m), .DRST(drst_m), .LOCKED(locked_m), .FAIL(fail_m),
    .TAP(tap_m), .SLIP(slip_m), .ERRCNT(err_m)
  );

  adc_frame_align #(.PATTERN(PAT), .MAXTAP(3)) u_fail (
    .CLK(clk), .RSTn(rstn), .START(start_f), .FRAME(6'b000000),
    .BS(bs_f), .DINC(dinc_f), .DRST(drst_f), .LOCKED(locked_f), .FAIL(fail_f),
    .TAP(tap_f), .SLIP(slip_f), .ERRCNT(err_f)
  );

  // Line model: the received word is PATTERN rotated by an offset that each bitslip reduces.
  int bs_seen = 0;
  int bs_base = 0;
  int amt;
  always @(posedge clk) if (bs_m === 1'b1) bs_seen <= bs_seen + 1;

  function automatic logic [5:0] rotl(input logic [5:0] v, input int n);
    logic [5:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[4:0], r[5]};
    return r;
  endfunction

  always_comb begin
    amt     = ((2 - (bs_seen - bs_base)) % 6 + 6) % 6;
    frame_m = use_model ? rotl(PAT, amt) : frame_drv;
  end

  ev_t   sb_m[$];
  ev_t   sb_f[$];
  snap_t snap_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    done = 1'b0;

  // Monitor: every pulse or lock/fail rise must match the head of its instance queue.
  logic locked_pm = 1'b0, fail_pm = 1'b0, locked_pf = 1'b0, fail_pf = 1'b0;
  bit   final_done = 1'b0;
  always @(negedge clk) begin
    logic [4:0] km, kf;
    ev_t   e;
    snap_t s;
    km = {fail_m & ~fail_pm, locked_m & ~locked_pm, dinc_m, bs_m, drst_m};
    kf = {fail_f & ~fail_pf, locked_f & ~locked_pf, dinc_f, bs_f, drst_f};
    if (km != 5'd0) begin
      n_vec++;
      if (sb_m.size() == 0) begin
        n_err++;
        $display("[TB] FAIL unexpected_ev_main: got kind=%b at cycle %0d, need no event", km, cyc);
      end else begin
        e = sb_m.pop_front();
        if (e.stamp != cyc || e.kind != km || e.tap != tap_m || e.slip != slip_m || e.err != err_m) begin
          n_err++;
          $display("[TB] FAIL ev_main: got cyc=%0d kind=%b tap=%0d slip=%0d err=%0d, need cyc=%0d kind=%b tap=%0d slip=%0d err=%0d",
                   cyc, km, tap_m, slip_m, err_m, e.stamp, e.kind, e.tap, e.slip, e.err);
        end
      end
    end
    if (kf != 5'd0) begin
      n_vec++;
      if (sb_f.size() == 0) begin
        n_err++;
        $display("[TB] FAIL unexpected_ev_fail: got kind=%b at cycle %0d, need no event", kf, cyc);
      end else begin
        e = sb_f.pop_front();
        if (e.stamp != cyc || e.kind != kf || e.tap != tap_f || e.slip != slip_f || e.err != err_f) begin
          n_err++;
          $display("[TB] FAIL ev_fail: got cyc=%0d kind=%b tap=%0d slip=%0d err=%0d, need cyc=%0d kind=%b tap=%0d slip=%0d err=%0d",
                   cyc, kf, tap_f, slip_f, err_f, e.stamp, e.kind, e.tap, e.slip, e.err);
        end
      end
    end
    while (snap_q.size() != 0 && snap_q[0].stamp <= cyc) begin
      logic [4:0]  a_tap;
      logic [2:0]  a_slip;
      logic [15:0] a_err;
      logic        a_lk, a_fl, a_pul;
      s      = snap_q.pop_front();
      a_tap  = s.inst ? tap_f : tap_m;
      a_slip = s.inst ? slip_f : slip_m;
      a_err  = s.inst ? err_f : err_m;
      a_lk   = s.inst ? locked_f : locked_m;
      a_fl   = s.inst ? fail_f : fail_m;
      a_pul  = s.inst ? (bs_f | dinc_f | drst_f) : (bs_m | dinc_m | drst_m);
      n_vec++;
      if (a_lk !== s.locked || a_fl !== s.fail || a_tap !== s.tap || a_slip !== s.slip ||
          a_err !== s.err || a_pul !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL %s: got locked=%b fail=%b tap=%0d slip=%0d err=%0d pulses=%b, need locked=%b fail=%b tap=%0d slip=%0d err=%0d pulses=0",
                 s.name, a_lk, a_fl, a_tap, a_slip, a_err, a_pul, s.locked, s.fail, s.tap, s.slip, s.err);
      end
    end
    if (done && !final_done) begin
      final_done = 1'b1;
      n_vec++;
      if (sb_m.size() != 0 || sb_f.size() != 0 || snap_q.size() != 0) begin
        n_err++;
        $display("[TB] FAIL pending_expectations: got main=%0d fail=%0d snap=%0d left, need 0",
                 sb_m.size(), sb_f.size(), snap_q.size());
      end
    end
    locked_pm = locked_m;
    fail_pm   = fail_m;
    locked_pf = locked_f;
    fail_pf   = fail_f;
  end

  task automatic waitTo(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // START is raised so that it is sampled at the next edge, whose number is returned.
  task automatic applyStimulus(input bit inst, output int k);
    k = cyc + 1;
    if (inst) start_f = 1'b1; else start_m = 1'b1;
    @(posedge clk);
    #1;
    start_f = 1'b0;
    start_m = 1'b0;
  endtask

  task automatic pushEv(input bit inst, input int stamp, input logic [4:0] kind,
                        input logic [4:0] tap, input logic [2:0] slip, input logic [15:0] err);
    ev_t e;
    e.stamp = stamp; e.kind = kind; e.tap = tap; e.slip = slip; e.err = err;
    if (inst) sb_f.push_back(e); else sb_m.push_back(e);
  endtask

  task automatic checkOutput(input bit inst, input string name, input logic locked, input logic fail,
                             input logic [4:0] tap, input logic [2:0] slip, input logic [15:0] err);
    snap_t s;
    s.stamp = cyc; s.inst = inst; s.name = name; s.locked = locked; s.fail = fail;
    s.tap = tap; s.slip = slip; s.err = err;
    snap_q.push_back(s);
  endtask

  // Expected events of a full search with a never-matching frame, from DRST at k.
  task automatic pushSearch(input bit inst, input int k, input int taps);
    for (int t = 0; t < taps; t++) begin
      for (int j = 1; j <= 5; j++) pushEv(inst, k + 60 * t + 10 * j, K_BS, 5'(t), 3'(j), 16'd0);
      pushEv(inst, k + 60 * t + 60, K_DINC, 5'(t + 1), 3'd0, 16'd0);
    end
  endtask

  initial begin
    int k;
    int n0;
    rstn = 1'b0; start_m = 1'b1; start_f = 1'b1;
    frame_drv = PAT; use_model = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput(0, "reset_main", 0, 0, 5'd0, 3'd0, 16'd0);
    checkOutput(1, "reset_fail", 0, 0, 5'd0, 3'd0, 16'd0);
    start_m = 1'b0; start_f = 1'b0; rstn = 1'b1;
    waitTo(cyc + 4);

    $display("[TB] exhausting taps with MAXTAP=3");
    applyStimulus(1, k);
    pushEv(1, k, K_DRST, 5'd0, 3'd0, 16'd0);
    pushSearch(1, k, 3);
    for (int j = 1; j <= 5; j++) pushEv(1, k + 180 + 10 * j, K_BS, 5'd3, 3'(j), 16'd0);
    pushEv(1, k + 240, K_FAIL, 5'd3, 3'd5, 16'd0);
    waitTo(k + 300);
    checkOutput(1, "failed_hold", 0, 1, 5'd3, 3'd5, 16'd0);

    $display("[TB] immediate lock");
    applyStimulus(0, k);
    pushEv(0, k, K_DRST, 5'd0, 3'd0, 16'd0);
    pushEv(0, k + 25, K_LOCK, 5'd0, 3'd0, 16'd0);
    waitTo(k + 30);
    checkOutput(0, "locked_direct", 1, 0, 5'd0, 3'd0, 16'd0);

    $display("[TB] five corrupted words while locked");
    frame_drv = 6'b000000;
    waitTo(cyc + 5);
    frame_drv = PAT;
    waitTo(cyc + 3);
    checkOutput(0, "errcnt_five", 1, 0, 5'd0, 3'd0, 16'd5);

    $display("[TB] rotating line model, offset 2");
    bs_base = bs_seen;
    use_model = 1'b1;
    applyStimulus(0, k);
    pushEv(0, k, K_DRST, 5'd0, 3'd0, 16'd0);
    pushEv(0, k + 10, K_BS, 5'd0, 3'd1, 16'd0);
    pushEv(0, k + 20, K_BS, 5'd0, 3'd2, 16'd0);
    pushEv(0, k + 45, K_LOCK, 5'd0, 3'd2, 16'd0);
    waitTo(k + 50);
    checkOutput(0, "locked_slip2", 1, 0, 5'd0, 3'd2, 16'd0);
    frame_drv = PAT;
    use_model = 1'b0;

    $display("[TB] restart mid-CHECK at tap 2");
    frame_drv = 6'b000000;
    applyStimulus(0, k);
    pushEv(0, k, K_DRST, 5'd0, 3'd0, 16'd0);
    pushSearch(0, k, 2);
    waitTo(k + 129);
    pushEv(0, k + 130, K_DRST, 5'd0, 3'd0, 16'd0);
    pushEv(0, k + 155, K_LOCK, 5'd0, 3'd0, 16'd0);
    frame_drv = PAT;
    start_m = 1'b1;
    @(posedge clk);
    #1;
    start_m = 1'b0;
    waitTo(k + 160);
    checkOutput(0, "locked_restart", 1, 0, 5'd0, 3'd0, 16'd0);

    $display("[TB] error counter saturation");
    frame_drv = 6'b000000;
    n0 = cyc;
    waitTo(n0 + 65534);
    checkOutput(0, "errcnt_fffe", 1, 0, 5'd0, 3'd0, 16'hFFFE);
    waitTo(n0 + 66000);
    checkOutput(0, "errcnt_sat", 1, 0, 5'd0, 3'd0, 16'hFFFF);

    $display("[TB] reset while locked");
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    checkOutput(0, "reset_locked", 0, 0, 5'd0, 3'd0, 16'd0);

    $display("[TB] reset during SLIPS with START held");
    applyStimulus(0, k);
    pushEv(0, k, K_DRST, 5'd0, 3'd0, 16'd0);
    pushEv(0, k + 10, K_BS, 5'd0, 3'd1, 16'd0);
    waitTo(k + 10);
    rstn = 1'b0;
    start_m = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    start_m = 1'b0;
    checkOutput(0, "reset_slips", 0, 0, 5'd0, 3'd0, 16'd0);
    waitTo(cyc + 80);
    checkOutput(0, "idle_after_slips", 0, 0, 5'd0, 3'd0, 16'd0);

    $display("[TB] reset during INC");
    applyStimulus(0, k);
    pushEv(0, k, K_DRST, 5'd0, 3'd0, 16'd0);
    pushSearch(0, k, 1);
    waitTo(k + 60);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    checkOutput(0, "reset_inc", 0, 0, 5'd0, 3'd0, 16'd0);
    waitTo(cyc + 80);
    checkOutput(0, "idle_after_inc", 0, 0, 5'd0, 3'd0, 16'd0);

    done = 1'b1;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
